msrh_stq_l1d_pipe: RTL and testbench

MSRH_STQ_L1D_PIPE -- requirements
Module: msrh_stq_l1d_pipe

---
 rtl/msrh_stq_l1d_pipe.sv | 183 ++++++++++++++++++
 tb/tb_msrh_stq_l1d_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_stq_l1d_pipe.sv
`default_nettype none
// ============================================================================
// Module   : msrh_stq_l1d_pipe
// Brief    : Store-queue to L1D commit pipe: S0 arbitrate, S1 tag/LRQ, S2 write.
//            Optional same-line hazard block: MSRH_STQ_L1D_PIPE_HAZARD_EN
// Revision : 1.0
// ============================================================================
module msrh_stq_l1d_pipe #(
    parameter int STQ_ENTRY_SIZE = 16,
    parameter int PADDR_W        = 56,
    parameter int XLEN_W         = 64,
    parameter int LINE_B_W       = 32,
    parameter int LRQ_ENTRY_SIZE = 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [STQ_ENTRY_SIZE-1:0]         i_req_valid,
    input  logic [PADDR_W-1:0]                i_req_paddr [STQ_ENTRY_SIZE],
    input  logic [XLEN_W-1:0]                 i_req_data  [STQ_ENTRY_SIZE],
    input  logic [1:0]                        i_req_size  [STQ_ENTRY_SIZE],
    input  logic [$clog2(STQ_ENTRY_SIZE)-1:0] i_stq_outptr,
    output logic [STQ_ENTRY_SIZE-1:0]         o_op_accept_oh,
    output logic                              o_l1d_rd_valid,
    output logic [PADDR_W-1:0]                o_l1d_rd_paddr,
    input  logic                              i_l1d_rd_hit,
    input  logic                              i_l1d_rd_conflict,
    output logic                              o_lrq_req_valid,
    output logic [PADDR_W-1:0]                o_lrq_req_paddr,
    input  logic                              i_lrq_full,
    input  logic                              i_lrq_conflict,
    input  logic [LRQ_ENTRY_SIZE-1:0]         i_lrq_index_oh,
    output logic [STQ_ENTRY_SIZE-1:0]         o_rd_miss_oh,
    output logic [STQ_ENTRY_SIZE-1:0]         o_rd_conflict_oh,
    output logic [LRQ_ENTRY_SIZE-1:0]         o_lrq_index_oh,
    output logic                              o_l1d_wr_valid,
    output logic [PADDR_W-1:0]                o_l1d_wr_paddr,
    output logic [LINE_B_W*8-1:0]             o_l1d_wr_data,
    output logic [LINE_B_W-1:0]               o_l1d_wr_be,
    input  logic                              i_l1d_wr_conflict,
    output logic [STQ_ENTRY_SIZE-1:0]         o_wr_conflict_oh,
    output logic [STQ_ENTRY_SIZE-1:0]         o_wr_done_oh,
    output logic [31:0]                       o_perf_rd_miss_cnt
);

    localparam int IDX_W  = $clog2(STQ_ENTRY_SIZE);
    localparam int OFS_W  = $clog2(LINE_B_W);
    localparam int LINE_W = LINE_B_W * 8;

    logic                      s1_valid_q, s1_valid_d;
    logic [STQ_ENTRY_SIZE-1:0] s1_oh_q, s1_oh_d;
    logic [PADDR_W-1:0]        s1_paddr_q, s1_paddr_d;
    logic [XLEN_W-1:0]         s1_data_q, s1_data_d;
    logic [1:0]                s1_size_q, s1_size_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [STQ_ENTRY_SIZE-1:0] s2_oh_q, s2_oh_d;
    logic [PADDR_W-1:0]        s2_paddr_q, s2_paddr_d;
    logic [XLEN_W-1:0]         s2_data_q, s2_data_d;
    logic [1:0]                s2_size_q, s2_size_d;
    logic [31:0]               perf_cnt_q, perf_cnt_d;

    logic                      w_sel_found;
    logic [IDX_W-1:0]          w_sel_idx;
    logic [IDX_W:0]            w_scan;
    logic [PADDR_W-1:0]        w_sel_paddr;
    logic                      w_hazard;
    logic                      w_accept;
    logic                      w_s1_conflict;
    logic                      w_s1_miss;
    logic                      w_s1_alloc;
    logic [LINE_W-1:0]         w_line_data;
    logic [LINE_B_W-1:0]       w_be_base;

    // S0: oldest-first scan starting at the out pointer, wrapping past the top entry
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan      = '0;
        for (int i = 0; i < STQ_ENTRY_SIZE; i++) begin
            w_scan = {1'b0, i_stq_outptr} + (IDX_W+1)'(i);
            if (w_scan >= (IDX_W+1)'(STQ_ENTRY_SIZE)) begin
                w_scan = w_scan - (IDX_W+1)'(STQ_ENTRY_SIZE);
            end
            if (!w_sel_found && i_req_valid[w_scan[IDX_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan[IDX_W-1:0];
            end
        end
    end

    assign w_sel_paddr = i_req_paddr[w_sel_idx];

`ifdef MSRH_STQ_L1D_PIPE_HAZARD_EN
    assign w_hazard = (s1_valid_q && (s1_paddr_q[PADDR_W-1:OFS_W] == w_sel_paddr[PADDR_W-1:OFS_W])) ||
                      (s2_valid_q && (s2_paddr_q[PADDR_W-1:OFS_W] == w_sel_paddr[PADDR_W-1:OFS_W]));
`else
    assign w_hazard = 1'b0;
`endif

    // Gated by reset so nothing is handed out while the pipe is held clear
    assign w_accept       = i_reset_n & w_sel_found & ~w_hazard;
    assign o_l1d_rd_valid = w_accept;
    assign o_l1d_rd_paddr = w_sel_paddr;

    always_comb begin
        o_op_accept_oh = '0;
        if (w_accept) begin
            o_op_accept_oh[w_sel_idx] = 1'b1;
        end
    end

    always_comb begin
        w_s1_conflict    = s1_valid_q & i_l1d_rd_conflict;
        w_s1_miss        = s1_valid_q & ~i_l1d_rd_conflict & ~i_l1d_rd_hit;
        w_s1_alloc       = w_s1_miss & ~i_lrq_full;
        o_lrq_req_valid  = w_s1_miss;
        o_lrq_req_paddr  = s1_paddr_q;
        o_rd_conflict_oh = (w_s1_conflict | (w_s1_miss & i_lrq_full)) ? s1_oh_q : '0;
        o_rd_miss_oh     = w_s1_alloc ? s1_oh_q : '0;
        o_lrq_index_oh   = (w_s1_alloc & i_lrq_conflict) ? i_lrq_index_oh : '0;
    end

    always_comb begin
        s1_valid_d = w_accept;
        s1_oh_d    = o_op_accept_oh;
        s1_paddr_d = w_sel_paddr;
        s1_data_d  = i_req_data[w_sel_idx];
        s1_size_d  = i_req_size[w_sel_idx];
        s2_valid_d = s1_valid_q & ~i_l1d_rd_conflict & i_l1d_rd_hit;
        s2_oh_d    = s1_oh_q;
        s2_paddr_d = s1_paddr_q;
        s2_data_d  = s1_data_q;
        s2_size_d  = s1_size_q;
        perf_cnt_d = perf_cnt_q + (w_s1_alloc ? 32'd1 : 32'd0);
    end

    // S2: place the store at its byte offset inside the line
    always_comb begin
        w_line_data                = '0;
        w_line_data[XLEN_W-1:0]    = s2_data_q;
        case (s2_size_q)
            2'd0:    w_be_base = LINE_B_W'(8'h01);
            2'd1:    w_be_base = LINE_B_W'(8'h03);
            2'd2:    w_be_base = LINE_B_W'(8'h0F);
            default: w_be_base = LINE_B_W'(8'hFF);
        endcase
        o_l1d_wr_valid   = s2_valid_q;
        o_l1d_wr_paddr   = s2_paddr_q;
        o_l1d_wr_data    = w_line_data << {s2_paddr_q[OFS_W-1:0], 3'b000};
        o_l1d_wr_be      = w_be_base << s2_paddr_q[OFS_W-1:0];
        o_wr_conflict_oh = (s2_valid_q &  i_l1d_wr_conflict) ? s2_oh_q : '0;
        o_wr_done_oh     = (s2_valid_q & ~i_l1d_wr_conflict) ? s2_oh_q : '0;
    end

    assign o_perf_rd_miss_cnt = perf_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_oh_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_oh_q    <= '0;
            perf_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_oh_q    <= s1_oh_d;
            s2_valid_q <= s2_valid_d;
            s2_oh_q    <= s2_oh_d;
            perf_cnt_q <= perf_cnt_d;
        end
    end

    // Payload is qualified by the stage valid, so it needs no reset
    always_ff @(posedge i_clk) begin
        s1_paddr_q <= s1_paddr_d;
        s1_data_q  <= s1_data_d;
        s1_size_q  <= s1_size_d;
        s2_paddr_q <= s2_paddr_d;
        s2_data_q  <= s2_data_d;
        s2_size_q  <= s2_size_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_msrh_stq_l1d_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrh_stq_l1d_pipe
// Brief    : Directed scenarios plus randomized traffic against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_msrh_stq_l1d_pipe;

`ifdef MSRH_STQ_L1D_PIPE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct {
        int          e;
        logic [55:0] pa;
        logic [63:0] d;
        logic [1:0]  sz;
        int          age;
    } txn_t;

    logic         clk;
    logic         reset_n;
    logic [15:0]  req_valid;
    logic [55:0]  req_paddr [16];
    logic [63:0]  req_data  [16];
    logic [1:0]   req_size  [16];
    logic [3:0]   outptr;
    logic         rd_hit, rd_conf, lrq_full, lrq_conf, wr_conf;
    logic [7:0]   lrq_idx;

    logic [15:0]  acc_oh, rd_miss_oh, rd_conf_oh, wr_conf_oh, wr_done_oh;
    logic         rd_valid, lrq_req_valid, wr_valid;
    logic [55:0]  rd_paddr, lrq_req_paddr, wr_paddr;
    logic [7:0]   lrq_index_oh;
    logic [255:0] wr_data;
    logic [31:0]  wr_be;
    logic [31:0]  miss_cnt;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [31:0]  exp_cnt = 32'd0;

    msrh_stq_l1d_pipe dut (
        .i_clk              (clk),
        .i_reset_n          (reset_n),
        .i_req_valid        (req_valid),
        .i_req_paddr        (req_paddr),
        .i_req_data         (req_data),
        .i_req_size         (req_size),
        .i_stq_outptr       (outptr),
        .o_op_accept_oh     (acc_oh),
        .o_l1d_rd_valid     (rd_valid),
        .o_l1d_rd_paddr     (rd_paddr),
        .i_l1d_rd_hit       (rd_hit),
        .i_l1d_rd_conflict  (rd_conf),
        .o_lrq_req_valid    (lrq_req_valid),
        .o_lrq_req_paddr    (lrq_req_paddr),
        .i_lrq_full         (lrq_full),
        .i_lrq_conflict     (lrq_conf),
        .i_lrq_index_oh     (lrq_idx),
        .o_rd_miss_oh       (rd_miss_oh),
        .o_rd_conflict_oh   (rd_conf_oh),
        .o_lrq_index_oh     (lrq_index_oh),
        .o_l1d_wr_valid     (wr_valid),
        .o_l1d_wr_paddr     (wr_paddr),
        .o_l1d_wr_data      (wr_data),
        .o_l1d_wr_be        (wr_be),
        .i_l1d_wr_conflict  (wr_conf),
        .o_wr_conflict_oh   (wr_conf_oh),
        .o_wr_done_oh       (wr_done_oh),
        .o_perf_rd_miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        req_valid = '0;
        outptr    = '0;
        rd_hit    = 1'b1;
        rd_conf   = 1'b0;
        lrq_full  = 1'b0;
        lrq_conf  = 1'b0;
        lrq_idx   = '0;
        wr_conf   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) next_cycle();
    endtask

    task automatic set_entry(input int e, input logic [55:0] pa, input logic [63:0] d, input logic [1:0] sz);
        req_paddr[e] = pa;
        req_data[e]  = d;
        req_size[e]  = sz;
    endtask

    task automatic test_reset();
        idle();
        req_valid = 16'hFFFF;
        #1;
        total_cnt++; if (acc_oh !== 16'h0)   $display("FAIL reset_accept: got %h want 0000", acc_oh); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0)  $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (lrq_req_valid !== 1'b0) $display("FAIL reset_lrq_valid: got %b want 0", lrq_req_valid); else pass_cnt++;
        total_cnt++; if (wr_valid !== 1'b0)  $display("FAIL reset_wr_valid: got %b want 0", wr_valid); else pass_cnt++;
        total_cnt++; if ((rd_miss_oh | rd_conf_oh | wr_conf_oh | wr_done_oh) !== 16'h0)
            $display("FAIL reset_result_oh: got %h want 0000", rd_miss_oh | rd_conf_oh | wr_conf_oh | wr_done_oh); else pass_cnt++;
        total_cnt++; if (miss_cnt !== 32'h0) $display("FAIL reset_miss_cnt: got %h want 0", miss_cnt); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_hit_done();
        next_cycle(); idle();
        set_entry(2, 56'h2004, 64'h0123_4567_89AB_CDEF, 2'd3);
        set_entry(1, 56'h3000, 64'h55, 2'd0);
        req_valid = 16'h0006; outptr = 4'd2; #1;
        total_cnt++; if (acc_oh !== 16'h0004) $display("FAIL hit_accept: got %h want 0004", acc_oh); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b1 || rd_paddr !== 56'h2004)
            $display("FAIL hit_rd_req: got %b/%h want 1/2004", rd_valid, rd_paddr); else pass_cnt++;
        next_cycle();
        req_valid = 16'h0002; #1;
        total_cnt++; if (acc_oh !== 16'h0002) $display("FAIL hit_accept_wrap: got %h want 0002", acc_oh); else pass_cnt++;
        total_cnt++; if ((rd_miss_oh | rd_conf_oh) !== 16'h0 || lrq_req_valid !== 1'b0)
            $display("FAIL hit_s1_quiet: got %h/%b want 0000/0", rd_miss_oh | rd_conf_oh, lrq_req_valid); else pass_cnt++;
        total_cnt++; if (wr_valid !== 1'b0) $display("FAIL hit_wr_early: got %b want 0", wr_valid); else pass_cnt++;
        next_cycle();
        req_valid = 16'h0000; #1;
        total_cnt++; if (wr_valid !== 1'b1 || wr_paddr !== 56'h2004)
            $display("FAIL hit_wr_req: got %b/%h want 1/2004", wr_valid, wr_paddr); else pass_cnt++;
        total_cnt++; if (wr_done_oh !== 16'h0004 || wr_conf_oh !== 16'h0)
            $display("FAIL hit_done: got %h/%h want 0004/0000", wr_done_oh, wr_conf_oh); else pass_cnt++;
        drain();
    endtask

    task automatic test_wrap();
        next_cycle(); idle();
        set_entry(15, 56'h4000, 64'h1, 2'd0);
        set_entry(0,  56'h5000, 64'h2, 2'd0);
        outptr = 4'd15; req_valid = 16'h8001; #1;
        total_cnt++; if (acc_oh !== 16'h8000) $display("FAIL wrap_first: got %h want 8000", acc_oh); else pass_cnt++;
        next_cycle();
        req_valid = 16'h0001; #1;
        total_cnt++; if (acc_oh !== 16'h0001) $display("FAIL wrap_second: got %h want 0001", acc_oh); else pass_cnt++;
        drain();
    endtask

    task automatic test_miss_lrq_conflict();
        next_cycle(); idle();
        set_entry(5, 56'h6040, 64'h77, 2'd1);
        req_valid = 16'h0020; #1;
        total_cnt++; if (acc_oh !== 16'h0020) $display("FAIL miss_accept: got %h want 0020", acc_oh); else pass_cnt++;
        next_cycle();
        req_valid = '0; rd_hit = 1'b0; lrq_conf = 1'b1; lrq_idx = 8'h04; #1;
        total_cnt++; if (lrq_req_valid !== 1'b1 || lrq_req_paddr !== 56'h6040)
            $display("FAIL miss_lrq_req: got %b/%h want 1/6040", lrq_req_valid, lrq_req_paddr); else pass_cnt++;
        total_cnt++; if (rd_miss_oh !== 16'h0020 || rd_conf_oh !== 16'h0)
            $display("FAIL miss_oh: got %h/%h want 0020/0000", rd_miss_oh, rd_conf_oh); else pass_cnt++;
        total_cnt++; if (lrq_index_oh !== 8'h04) $display("FAIL miss_lrq_index: got %h want 04", lrq_index_oh); else pass_cnt++;
        exp_cnt = exp_cnt + 32'd1;
        next_cycle(); idle(); #1;
        total_cnt++; if (wr_valid !== 1'b0) $display("FAIL miss_no_write: got %b want 0", wr_valid); else pass_cnt++;
        total_cnt++; if (miss_cnt !== exp_cnt) $display("FAIL miss_cnt_inc: got %h want %h", miss_cnt, exp_cnt); else pass_cnt++;
        drain();
    endtask

    task automatic test_miss_full();
        next_cycle(); idle();
        set_entry(6, 56'h7000, 64'h88, 2'd2);
        req_valid = 16'h0040; #1;
        total_cnt++; if (acc_oh !== 16'h0040) $display("FAIL full_accept: got %h want 0040", acc_oh); else pass_cnt++;
        next_cycle();
        req_valid = '0; rd_hit = 1'b0; lrq_full = 1'b1; lrq_conf = 1'b1; lrq_idx = 8'h10; #1;
        total_cnt++; if (rd_conf_oh !== 16'h0040 || rd_miss_oh !== 16'h0)
            $display("FAIL full_oh: got %h/%h want 0040/0000", rd_conf_oh, rd_miss_oh); else pass_cnt++;
        total_cnt++; if (lrq_req_valid !== 1'b1 || lrq_index_oh !== 8'h0)
            $display("FAIL full_lrq: got %b/%h want 1/00", lrq_req_valid, lrq_index_oh); else pass_cnt++;
        next_cycle(); idle(); #1;
        total_cnt++; if (wr_valid !== 1'b0 || (wr_done_oh | wr_conf_oh) !== 16'h0)
            $display("FAIL full_no_write: got %b/%h want 0/0000", wr_valid, wr_done_oh | wr_conf_oh); else pass_cnt++;
        total_cnt++; if (miss_cnt !== exp_cnt) $display("FAIL full_cnt_hold: got %h want %h", miss_cnt, exp_cnt); else pass_cnt++;
        drain();
    endtask

    task automatic test_write_merge();
        logic [255:0] exp_d;
        exp_d = '0;
        exp_d[64 +: 8] = 8'hDD;
        exp_d[72 +: 8] = 8'hCC;
        exp_d[80 +: 8] = 8'hBB;
        exp_d[88 +: 8] = 8'hAA;
        next_cycle(); idle();
        set_entry(3, 56'h1008, 64'hAABB_CCDD, 2'd2);
        req_valid = 16'h0008; #1;
        total_cnt++; if (acc_oh !== 16'h0008) $display("FAIL merge_accept: got %h want 0008", acc_oh); else pass_cnt++;
        next_cycle(); req_valid = '0;
        next_cycle(); wr_conf = 1'b1; #1;
        total_cnt++; if (wr_be !== 32'h0000_0F00) $display("FAIL merge_be: got %h want 00000f00", wr_be); else pass_cnt++;
        total_cnt++; if (wr_data !== exp_d) $display("FAIL merge_data: got %h want %h", wr_data, exp_d); else pass_cnt++;
        total_cnt++; if (wr_conf_oh !== 16'h0008 || wr_done_oh !== 16'h0)
            $display("FAIL merge_wr_conflict: got %h/%h want 0008/0000", wr_conf_oh, wr_done_oh); else pass_cnt++;
        drain();
    endtask

    task automatic test_hazard();
        logic [15:0] pend;
        logic [15:0] exp_a;
        next_cycle(); idle();
        set_entry(1, 56'h1000, 64'h1111, 2'd3);
        set_entry(2, 56'h1010, 64'h2222, 2'd3);
        outptr = 4'd1; req_valid = 16'h0006; #1;
        total_cnt++; if (acc_oh !== 16'h0002) $display("FAIL hazard_first: got %h want 0002", acc_oh); else pass_cnt++;
        pend = 16'h0004;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            req_valid = pend; #1;
            exp_a = HAZ ? ((k == 3) ? 16'h0004 : 16'h0000) : ((k == 1) ? 16'h0004 : 16'h0000);
            total_cnt++; if (acc_oh !== exp_a) $display("FAIL hazard_cycle%0d: got %h want %h", k, acc_oh, exp_a); else pass_cnt++;
            if (exp_a != 16'h0) pend = 16'h0;
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        next_cycle(); idle();
        set_entry(4, 56'h8000, 64'h99, 2'd3);
        req_valid = 16'h0010; #1;
        total_cnt++; if (acc_oh !== 16'h0010) $display("FAIL rstfl_accept: got %h want 0010", acc_oh); else pass_cnt++;
        next_cycle();
        reset_n = 1'b0; exp_cnt = 32'd0; #1;
        total_cnt++; if ((rd_miss_oh | rd_conf_oh) !== 16'h0 || lrq_req_valid !== 1'b0 || acc_oh !== 16'h0)
            $display("FAIL rstfl_s1: got %h/%b/%h want 0000/0/0000", rd_miss_oh | rd_conf_oh, lrq_req_valid, acc_oh); else pass_cnt++;
        total_cnt++; if (miss_cnt !== exp_cnt) $display("FAIL rstfl_cnt: got %h want %h", miss_cnt, exp_cnt); else pass_cnt++;
        next_cycle();
        total_cnt++; if (wr_valid !== 1'b0 || (wr_done_oh | wr_conf_oh) !== 16'h0)
            $display("FAIL rstfl_s2: got %b/%h want 0/0000", wr_valid, wr_done_oh | wr_conf_oh); else pass_cnt++;
        reset_n = 1'b1; req_valid = '0;
        next_cycle(); #1;
        total_cnt++; if (wr_valid !== 1'b0 || wr_done_oh !== 16'h0 || rd_miss_oh !== 16'h0)
            $display("FAIL rstfl_after: got %b/%h/%h want 0/0000/0000", wr_valid, wr_done_oh, rd_miss_oh); else pass_cnt++;
        drain();
    endtask

    task automatic test_random();
        txn_t         fl[$];
        txn_t         nq[$];
        txn_t         t;
        bit           busy[16];
        int           sel, e, idx1, idx2, pos;
        bit           haz;
        logic [15:0]  exp_acc, exp_rdc, exp_rdm, exp_wc, exp_wd;
        logic         exp_lrqv;
        logic [7:0]   exp_lrqi;
        logic [255:0] exp_d;
        logic [31:0]  exp_be;
        foreach (busy[i]) busy[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            next_cycle();
            outptr = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                if (busy[k]) begin
                    req_valid[k] = 1'b0;
                end else begin
                    req_valid[k] = ($urandom_range(0, 2) == 0);
                    set_entry(k, 56'h10000 + 56'($urandom_range(0, 3)) * 56'd32 + 56'($urandom_range(0, 31)),
                              {$urandom, $urandom}, 2'($urandom_range(0, 3)));
                end
            end
            rd_hit   = ($urandom_range(0, 3) != 0);
            rd_conf  = ($urandom_range(0, 5) == 0);
            lrq_full = ($urandom_range(0, 3) == 0);
            lrq_conf = 1'($urandom_range(0, 1));
            lrq_idx  = 8'(1 << $urandom_range(0, 7));
            wr_conf  = ($urandom_range(0, 4) == 0);
            #1;
            // S0: oldest ready entry, unless its line is still in flight
            sel = -1;
            for (int k = 0; k < 16; k++) begin
                e = (int'(outptr) + k) % 16;
                if (sel < 0 && req_valid[e]) sel = e;
            end
            haz = 1'b0;
            if (HAZ && sel >= 0)
                foreach (fl[i]) if (fl[i].pa[55:5] == req_paddr[sel][55:5]) haz = 1'b1;
            exp_acc = (sel >= 0 && !haz) ? 16'(1 << sel) : 16'h0;
            total_cnt++; if (acc_oh !== exp_acc) $display("FAIL rnd_accept c%0d: got %h want %h", cyc, acc_oh, exp_acc); else pass_cnt++;
            total_cnt++; if (rd_valid !== (exp_acc != 0)) $display("FAIL rnd_rd_valid c%0d: got %b", cyc, rd_valid); else pass_cnt++;
            if (exp_acc != 0) begin
                total_cnt++; if (rd_paddr !== req_paddr[sel]) $display("FAIL rnd_rd_paddr c%0d: got %h want %h", cyc, rd_paddr, req_paddr[sel]); else pass_cnt++;
            end
            idx1 = -1; idx2 = -1;
            foreach (fl[i]) begin
                if (fl[i].age == 1) idx1 = i;
                if (fl[i].age == 2) idx2 = i;
            end
            exp_rdc = '0; exp_rdm = '0; exp_lrqv = 1'b0; exp_lrqi = '0;
            if (idx1 >= 0) begin
                t = fl[idx1];
                if (rd_conf) exp_rdc = 16'(1 << t.e);
                else if (!rd_hit) begin
                    exp_lrqv = 1'b1;
                    if (lrq_full) exp_rdc = 16'(1 << t.e);
                    else begin
                        exp_rdm  = 16'(1 << t.e);
                        exp_lrqi = lrq_conf ? lrq_idx : 8'h0;
                    end
                end
            end
            total_cnt++; if (rd_conf_oh !== exp_rdc) $display("FAIL rnd_rd_conflict c%0d: got %h want %h", cyc, rd_conf_oh, exp_rdc); else pass_cnt++;
            total_cnt++; if (rd_miss_oh !== exp_rdm) $display("FAIL rnd_rd_miss c%0d: got %h want %h", cyc, rd_miss_oh, exp_rdm); else pass_cnt++;
            total_cnt++; if (lrq_req_valid !== exp_lrqv) $display("FAIL rnd_lrq_valid c%0d: got %b want %b", cyc, lrq_req_valid, exp_lrqv); else pass_cnt++;
            total_cnt++; if (lrq_index_oh !== exp_lrqi) $display("FAIL rnd_lrq_index c%0d: got %h want %h", cyc, lrq_index_oh, exp_lrqi); else pass_cnt++;
            if (exp_lrqv) begin
                total_cnt++; if (lrq_req_paddr !== t.pa) $display("FAIL rnd_lrq_paddr c%0d: got %h want %h", cyc, lrq_req_paddr, t.pa); else pass_cnt++;
            end
            exp_wc = '0; exp_wd = '0;
            total_cnt++; if (wr_valid !== (idx2 >= 0)) $display("FAIL rnd_wr_valid c%0d: got %b", cyc, wr_valid); else pass_cnt++;
            if (idx2 >= 0) begin
                t = fl[idx2];
                exp_d = '0; exp_be = '0;
                for (int b = 0; b < 8; b++) begin
                    pos = int'(t.pa[4:0]) + b;
                    if (pos < 32) begin
                        exp_d[pos*8 +: 8] = t.d[b*8 +: 8];
                        if (b < (1 << t.sz)) exp_be[pos] = 1'b1;
                    end
                end
                if (wr_conf) exp_wc = 16'(1 << t.e); else exp_wd = 16'(1 << t.e);
                total_cnt++; if (wr_paddr !== t.pa) $display("FAIL rnd_wr_paddr c%0d: got %h want %h", cyc, wr_paddr, t.pa); else pass_cnt++;
                total_cnt++; if (wr_be !== exp_be) $display("FAIL rnd_wr_be c%0d: got %h want %h", cyc, wr_be, exp_be); else pass_cnt++;
                total_cnt++; if (wr_data !== exp_d) $display("FAIL rnd_wr_data c%0d: got %h want %h", cyc, wr_data, exp_d); else pass_cnt++;
            end
            total_cnt++; if (wr_conf_oh !== exp_wc) $display("FAIL rnd_wr_conflict c%0d: got %h want %h", cyc, wr_conf_oh, exp_wc); else pass_cnt++;
            total_cnt++; if (wr_done_oh !== exp_wd) $display("FAIL rnd_wr_done c%0d: got %h want %h", cyc, wr_done_oh, exp_wd); else pass_cnt++;
            total_cnt++; if (miss_cnt !== exp_cnt) $display("FAIL rnd_miss_cnt c%0d: got %h want %h", cyc, miss_cnt, exp_cnt); else pass_cnt++;
            // Retire finished transactions and age the survivors
            if (idx1 >= 0 && (rd_conf || !rd_hit)) begin
                busy[fl[idx1].e] = 1'b0;
                if (!rd_conf && !lrq_full) exp_cnt = exp_cnt + 32'd1;
            end
            if (idx2 >= 0) busy[fl[idx2].e] = 1'b0;
            nq.delete();
            foreach (fl[i]) begin
                if (fl[i].age == 1 && !rd_conf && rd_hit) begin
                    t = fl[i];
                    t.age = 2;
                    nq.push_back(t);
                end
            end
            if (exp_acc != 0) begin
                t.e = sel; t.pa = req_paddr[sel]; t.d = req_data[sel]; t.sz = req_size[sel]; t.age = 1;
                nq.push_back(t);
                busy[sel] = 1'b1;
            end
            fl = nq;
        end
        drain();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) set_entry(k, 56'h0, 64'h0, 2'd0);
        reset_n = 1'b1;
        idle();
        #2;
        reset_n = 1'b0;
        test_reset();
        test_hit_done();
        test_wrap();
        test_miss_lrq_conflict();
        test_miss_full();
        test_write_merge();
        test_hazard();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
